// File: rtl/st_elastic_pipe.sv
// st_elastic_pipe
//   Elastic pipeline stage for an Avalon-ST stream with packet framing.
//   Beats go through a circular buffer of DEPTH entries. Every output is
//   driven from flops, so there is no combinational path from din to dout
//   and none from dout_ready to din_ready.
//   The block also reports how many entries it holds, flags framing errors
//   seen on the input, and counts the packets it has fully emitted.
//
// Ports
//   clock, reset                     rising-edge clock; asynchronous active-high reset
//   din_data/valid/ready/sop/eop     sink side (readyLatency 0)
//   dout_data/valid/ready/sop/eop    source side (readyLatency 0)
//   level                            number of entries currently stored
//   err_clr                          synchronous clear of frame_err
//   frame_err                        sticky flag for an input framing violation
//   pkt_count                        packets whose eop beat was popped (wraps)
//
// DEPTH must be a power of 2 and at least 2, so the pointers wrap for free.
module st_elastic_pipe #(
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 2,
  parameter int PKT_CNT_W = 16,
  localparam int LW       = $clog2(DEPTH + 1),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    din_data,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 din_startofpacket,
  input  logic                 din_endofpacket,
  output logic [DATA_W-1:0]    dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_startofpacket,
  output logic                 dout_endofpacket,
  output logic [LW-1:0]        level,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t                mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 init_q;
  logic                 rdy_q;
  logic                 in_pkt_q, in_pkt_d;
  logic                 frame_err_q, frame_err_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic                 push, pop, viol;
  beat_t                head;

  assign head = mem_q[rd_ptr_q];
  assign push = din_valid & rdy_q;
  assign pop  = (level_q != '0) & dout_ready;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Framing monitor. A sop while a packet is open reopens a new packet.
  // A non-sop beat outside a packet leaves in_pkt closed.
  always_comb begin
    viol        = 1'b0;
    in_pkt_d    = in_pkt_q;
    frame_err_d = err_clr ? 1'b0 : frame_err_q;
    if (push) begin
      if (din_startofpacket) begin
        viol     = in_pkt_q;
        in_pkt_d = ~din_endofpacket;
      end else begin
        viol     = ~in_pkt_q;
        in_pkt_d = in_pkt_q & ~din_endofpacket;
      end
    end
    // A violation in the same cycle as err_clr takes priority.
    frame_err_d = frame_err_d | viol;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      init_q      <= 1'b0;
      rdy_q       <= 1'b0;
      in_pkt_q    <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      init_q <= 1'b1;
      // Ready is computed from the next level. The first edge after reset
      // is masked, so ready rises only on the second edge.
      rdy_q       <= init_q & (level_d != LW'(DEPTH));
      level_q     <= level_d;
      in_pkt_q    <= in_pkt_d;
      frame_err_q <= frame_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop && head.eop) pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{sop: din_startofpacket, eop: din_endofpacket, data: din_data};
  end

  assign din_ready          = rdy_q;
  assign dout_valid         = (level_q != '0);
  assign dout_data          = head.data;
  assign dout_startofpacket = head.sop;
  assign dout_endofpacket   = head.eop;
  assign level              = level_q;
  assign frame_err          = frame_err_q;
  assign pkt_count          = pkt_cnt_q;

endmodule

// File: tb/tb_st_elastic_pipe.sv
module tb_st_elastic_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: DEPTH=2, 2-bit packet counter (wrap is visible quickly)
  logic [23:0] a_data, a_ddata;
  logic a_vin, a_rdy, a_sop, a_eop, a_dval, a_dready, a_dsop, a_deop, a_clr, a_ferr;
  logic [1:0] a_level;
  logic [1:0] a_pc;

  // DUT B: DEPTH=4, 16-bit packet counter
  logic [23:0] b_data, b_ddata;
  logic b_vin, b_rdy, b_sop, b_eop, b_dval, b_dready, b_dsop, b_deop, b_clr, b_ferr;
  logic [2:0] b_level;
  logic [15:0] b_pc;

  st_elastic_pipe #(.DATA_W(24), .DEPTH(2), .PKT_CNT_W(2)) u_a (
    .clock(clk), .reset(rst),
    .din_data(a_data), .din_valid(a_vin), .din_ready(a_rdy),
    .din_startofpacket(a_sop), .din_endofpacket(a_eop),
    .dout_data(a_ddata), .dout_valid(a_dval), .dout_ready(a_dready),
    .dout_startofpacket(a_dsop), .dout_endofpacket(a_deop),
    .level(a_level), .err_clr(a_clr), .frame_err(a_ferr), .pkt_count(a_pc));

  st_elastic_pipe #(.DATA_W(24), .DEPTH(4), .PKT_CNT_W(16)) u_b (
    .clock(clk), .reset(rst),
    .din_data(b_data), .din_valid(b_vin), .din_ready(b_rdy),
    .din_startofpacket(b_sop), .din_endofpacket(b_eop),
    .dout_data(b_ddata), .dout_valid(b_dval), .dout_ready(b_dready),
    .dout_startofpacket(b_dsop), .dout_endofpacket(b_deop),
    .level(b_level), .err_clr(b_clr), .frame_err(b_ferr), .pkt_count(b_pc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for DUT A: a FIFO of beats plus the framing rules.
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } bt_t;
  bt_t mq[$];
  int  m_edges, m_pc, m_pushes, n_obs_pop;
  bit  m_inpkt, m_ferr;

  task automatic model_reset();
    mq.delete();
    m_edges = 0; m_pc = 0; m_inpkt = 0; m_ferr = 0;
  endtask

  // Drive A at a negedge, advance one clock, and check A against the model.
  task automatic cyc_a(input int vin, input int sop, input int eop, input int data,
                       input int rdy, input int clr);
    bit m_rdy, push, pop, viol;
    bt_t nb;
    a_vin = (vin != 0); a_sop = (sop != 0); a_eop = (eop != 0);
    a_data = 24'(data); a_dready = (rdy != 0); a_clr = (clr != 0);
    m_rdy = (m_edges >= 2) && (mq.size() < 2);
    push  = (vin != 0) && m_rdy;
    pop   = (mq.size() != 0) && (rdy != 0);
    if (a_dval && a_dready) n_obs_pop++;
    nb = '{sop: a_sop, eop: a_eop, data: a_data};
    @(posedge clk);
    if (pop) begin
      if (mq[0].eop) m_pc++;
      void'(mq.pop_front());
    end
    if (push) begin
      mq.push_back(nb);
      m_pushes++;
    end
    viol = 0;
    if (push) begin
      viol    = nb.sop ? m_inpkt : !m_inpkt;
      m_inpkt = nb.sop ? !nb.eop : (m_inpkt && !nb.eop);
    end
    if (clr != 0) m_ferr = 0;
    if (viol) m_ferr = 1;
    m_edges++;
    @(negedge clk);
    chk("a_valid", 32'(a_dval), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("a_head", 32'({a_dsop, a_deop, a_ddata}), 32'(mq[0]));
    chk("a_level", 32'(a_level), 32'(mq.size()));
    chk("a_din_ready", 32'(a_rdy), 32'((m_edges >= 2) && (mq.size() != 2)));
    chk("a_frame_err", 32'(a_ferr), 32'(m_ferr));
    chk("a_pkt_count", 32'(a_pc), 32'(m_pc % 4));
  endtask

  typedef struct {
    int vin, sop, eop, data, rdy, clr;
    int ev, ed, el, ef, epc;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int nxt, exp_b, cycles;
    bit will_push;

    // Directed vectors: 4-beat packet, framing errors, err_clr, counter wrap.
    tbl[0]  = '{1,1,0,1,1,0,   1,1,1,0,0};
    tbl[1]  = '{1,0,0,2,1,0,   1,2,1,0,0};
    tbl[2]  = '{1,0,0,3,1,0,   1,3,1,0,0};
    tbl[3]  = '{1,0,1,4,1,0,   1,4,1,0,0};
    tbl[4]  = '{0,0,0,0,1,0,   0,0,0,0,1};
    tbl[5]  = '{1,1,0,5,1,0,   1,5,1,0,1};
    tbl[6]  = '{1,0,0,6,1,0,   1,6,1,0,1};
    tbl[7]  = '{1,1,0,7,1,0,   1,7,1,1,1};
    tbl[8]  = '{0,0,0,0,1,1,   0,0,0,0,1};
    tbl[9]  = '{1,0,1,8,1,0,   1,8,1,0,1};
    tbl[10] = '{1,0,0,9,1,0,   1,9,1,1,2};
    tbl[11] = '{1,0,0,10,1,1,  1,10,1,1,2};
    tbl[12] = '{0,0,0,0,1,0,   0,0,0,1,2};
    tbl[13] = '{1,1,1,11,1,0,  1,11,1,1,2};
    tbl[14] = '{1,1,1,12,1,0,  1,12,1,1,3};
    tbl[15] = '{1,1,1,13,1,0,  1,13,1,1,0};
    tbl[16] = '{1,1,1,14,1,0,  1,14,1,1,1};
    tbl[17] = '{1,1,1,15,1,0,  1,15,1,1,2};
    tbl[18] = '{0,0,0,0,1,0,   0,0,0,1,3};

    rst = 1'b1;
    {a_vin, a_sop, a_eop, a_dready, a_clr} = '0; a_data = '0;
    {b_vin, b_sop, b_eop, b_dready, b_clr} = '0; b_data = '0;
    m_pushes = 0; n_obs_pop = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 32'(a_dval), 0);
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_a_ready", 32'(a_rdy), 0);
    chk("rst_a_ferr",  32'(a_ferr), 0);
    chk("rst_a_pc",    32'(a_pc), 0);
    chk("rst_b_ready", 32'(b_rdy), 0);
    rst = 1'b0;

    // T1/T4/T5
    cyc_a(0,0,0,0,0,0);
    cyc_a(0,0,0,0,0,0);
    for (int i = 0; i < 19; i++) begin
      cyc_a(tbl[i].vin, tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(a_dval), 32'(tbl[i].ev));
      if (tbl[i].ev != 0) chk($sformatf("tbl%0d_data", i), 32'(a_ddata), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_level", i), 32'(a_level), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_ferr", i), 32'(a_ferr), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_pc", i), 32'(a_pc), 32'(tbl[i].epc));
    end

    // T3: random traffic on A against the model, with a full-rate window.
    m_pushes = 0;
    cycles = 0;
    while (m_pushes < 1000 && cycles < 6000) begin
      if (cycles == 300) n_obs_pop = 0;
      if (cycles >= 300 && cycles < 340)
        cyc_a(1, $urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom, 1, 0);
      else
        cyc_a($urandom_range(0,1), $urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
              $urandom, $urandom_range(0,2) != 0, $urandom_range(0,19) == 0);
      if (cycles == 339) chk("full_rate_pops", 32'(n_obs_pop >= 39), 1);
      cycles++;
    end
    chk("rand_pushes_done", 32'(m_pushes >= 1000), 1);
    repeat (4) cyc_a(0,0,0,0,1,0);
    chk("rand_drained", 32'(a_level), 0);

    // T2: DEPTH=4 fills, then drains in order.
    b_dready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("b_ready_fill", 32'(b_rdy), 1);
      b_vin = 1'b1; b_sop = (k == 1); b_eop = 1'b0; b_data = 24'(k);
      @(posedge clk); @(negedge clk);
    end
    chk("b_level_full", 32'(b_level), 4);
    chk("b_ready_full", 32'(b_rdy), 0);
    chk("b_head_full", 32'(b_ddata), 1);
    nxt = 5; exp_b = 1;
    b_dready = 1'b1;
    for (int c = 0; c < 40 && (exp_b <= 6 || nxt <= 6); c++) begin
      b_vin = (nxt <= 6); b_sop = 1'b0; b_eop = (nxt == 6); b_data = 24'(nxt);
      will_push = b_vin && b_rdy;
      if (b_dval) begin
        chk("b_order", 32'(b_ddata), 32'(exp_b));
        chk("b_eop", 32'(b_deop), 32'(exp_b == 6));
        exp_b++;
      end
      @(posedge clk); @(negedge clk);
      if (will_push) nxt++;
    end
    b_vin = 1'b0;
    chk("b_all_emitted", 32'(exp_b), 7);
    chk("b_level_empty", 32'(b_level), 0);
    chk("b_pkt_count", 32'(b_pc), 1);
    chk("b_ferr", 32'(b_ferr), 0);

    // T6: reset while A holds two beats mid-packet.
    cyc_a(1,1,0,100,0,0);
    cyc_a(1,0,0,101,0,0);
    chk("t6_level_pre", 32'(a_level), 2);
    a_vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_async", 32'(a_dval), 0);
    chk("t6_level_async", 32'(a_level), 0);
    chk("t6_ready_async", 32'(a_rdy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc_a(0,0,0,0,1,0);
    cyc_a(0,0,0,0,1,0);
    cyc_a(1,1,1,55,1,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
